// File: rtl/sramctrl_pkg.sv
// Shared types and helpers for the AHB SRAM controller: FSM states, transfer
// size codes, lane widths and the byte-lane enable decoder.
package sramctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HALF  = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;

  localparam int LANE_W_PAR = 9;
  localparam int LANE_W     = 8;
  localparam int MAX_NL     = 8;

  // Lane mask for a transfer. Offset bits below the transfer size are
  // dropped, so unaligned addresses snap down to the natural boundary.
  // Sizes at least as wide as the bus (and undefined codes) enable all lanes.
  function automatic logic [MAX_NL-1:0] lane_mask(input logic [2:0] size,
                                                  input logic [2:0] low_addr,
                                                  input int         nl);
    logic [MAX_NL-1:0] all_lanes;
    logic [MAX_NL-1:0] mask;
    logic [2:0]        ofs;
    all_lanes = (nl >= MAX_NL) ? {MAX_NL{1'b1}} : {{(MAX_NL-4){1'b0}}, 4'hF};
    ofs       = low_addr & 3'(nl - 1);
    case (size)
      SZ_BYTE: mask = MAX_NL'(1) << ofs;
      SZ_HALF: mask = MAX_NL'(3) << {ofs[2:1], 1'b0};
      SZ_WORD: mask = MAX_NL'(15) << {ofs[2], 2'b00};
      default: mask = all_lanes;
    endcase
    return mask & all_lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_gen2_if.sv
// Request/acknowledge bus between the AHB-Lite slave front end (master side)
// and the SRAM controller (slave side).
interface ahb_sram_ctrl_gen2_if #(
  parameter int DWIDTH = 32
);
  logic              ahbsram_req;
  logic              ahbsram_write;
  logic [2:0]        ahbsram_size;
  logic [19:0]       ahbsram_addr;
  logic [DWIDTH-1:0] ahbsram_wdata;
  logic              sramahb_ack;
  logic [DWIDTH-1:0] sramahb_rdata;
  logic              busy;
  logic              parity_err;

  modport master (
    output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
    input  sramahb_ack, sramahb_rdata, busy, parity_err
  );

  modport slave (
    input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata,
    output sramahb_ack, sramahb_rdata, busy, parity_err
  );
endinterface

// File: rtl/sram_lane_bank.sv
// One byte lane of SRAM: synchronous write, registered read output followed
// by a free-running pipe so the lane output lags the address by RD_LATENCY.
import sramctrl_pkg::*;

module sram_lane_bank #(
  parameter int DEPTH      = 512,
  parameter int LW         = LANE_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [LW-1:0]            wdata,
  output logic [LW-1:0]            rdata
);

  logic [LW-1:0] mem [DEPTH];
  logic [LW-1:0] rd_p [RD_LATENCY];

  // Array write plus read pipe; the pipe reads every cycle, the controller
  // decides which cycle's output it keeps.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rd_p[0] <= mem[addr];
    for (int i = 1; i < RD_LATENCY; i++) rd_p[i] <= rd_p[i-1];
  end

  assign rdata = rd_p[RD_LATENCY-1];

endmodule

// File: rtl/ahb_sram_ctrl_gen2.sv
// Second-generation AHB SRAM controller: zero-fills the array after reset,
// then serves single request/acknowledge byte-lane reads and writes.
// Optional per-byte even parity is built when SRAMCTRL_PARITY_EN is defined.
import sramctrl_pkg::*;

module ahb_sram_ctrl_gen2 #(
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 512,
  parameter int RD_LATENCY = 1
) (
  input logic                 HCLK,
  input logic                 HRESET,
  ahb_sram_ctrl_gen2_if.slave bus
);

  localparam int NL  = DWIDTH / 8;
  localparam int LSB = $clog2(NL);
  localparam int AW  = $clog2(DEPTH);
`ifdef SRAMCTRL_PARITY_EN
  localparam int LW  = LANE_W_PAR;
`else
  localparam int LW  = LANE_W;
`endif
  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     sweep_cnt;
  logic [1:0]        lat_cnt;
  logic [AW-1:0]     word_idx;
  logic [MAX_NL-1:0] lane_mask_full;
  logic [NL-1:0]     lane_en;
  logic [AW-1:0]     ram_addr;
  logic [NL-1:0]     ram_we;
  logic [LW-1:0]     lane_wdata [NL];
  logic [LW-1:0]     ram_wdata  [NL];
  logic [LW-1:0]     lane_rdata [NL];
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] rdata_q;
  logic              ack_q;
  logic              wr_done;
  logic              rd_done;
  logic              unused_bits;
`ifdef SRAMCTRL_PARITY_EN
  logic              rd_par_bad;
  logic              perr_q;
`endif

  assign word_idx       = bus.ahbsram_addr[LSB +: AW];
  assign lane_mask_full = lane_mask(bus.ahbsram_size, bus.ahbsram_addr[2:0], NL);
  assign lane_en        = lane_mask_full[NL-1:0];
  assign unused_bits    = ^{bus.ahbsram_addr[19:LSB+AW], lane_mask_full};

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_cnt == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      ST_IDLE: if (bus.ahbsram_req) state_nxt = bus.ahbsram_write ? ST_WR : ST_RD;
      ST_WR:   state_nxt = ST_IDLE;
      ST_RD:   if (lat_cnt == 2'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Per-state outputs: busy, SRAM port steering and completion strobes.
  always_comb begin
    bus.busy = (state != ST_IDLE);
    ram_addr = word_idx;
    ram_we   = '0;
    for (int i = 0; i < NL; i++) ram_wdata[i] = lane_wdata[i];
    wr_done  = (state == ST_WR);
    rd_done  = (state == ST_RD) && (lat_cnt == 2'd0);
    case (state)
      ST_INIT: begin
        ram_addr = sweep_cnt;
        ram_we   = '1;
        for (int i = 0; i < NL; i++) ram_wdata[i] = '0;
      end
      ST_IDLE: if (bus.ahbsram_req && bus.ahbsram_write) ram_we = lane_en;
      default: ;
    endcase
  end

  // Zero-fill sweep counter and read latency countdown.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sweep_cnt <= '0;
      lat_cnt   <= '0;
    end else begin
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + 1'b1;
      if (state == ST_IDLE && bus.ahbsram_req && !bus.ahbsram_write)
        lat_cnt <= LAT_LOAD;
      else if (state == ST_RD && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 1'b1;
    end
  end

  // Split the write bus into lanes (with parity) and rebuild the read word.
  always_comb begin
    rd_word = '0;
`ifdef SRAMCTRL_PARITY_EN
    rd_par_bad = 1'b0;
`endif
    for (int i = 0; i < NL; i++) begin
`ifdef SRAMCTRL_PARITY_EN
      lane_wdata[i] = {^bus.ahbsram_wdata[8*i +: 8], bus.ahbsram_wdata[8*i +: 8]};
      if (lane_rdata[i][8] != ^lane_rdata[i][7:0]) rd_par_bad = 1'b1;
`else
      lane_wdata[i] = bus.ahbsram_wdata[8*i +: 8];
`endif
      rd_word[8*i +: 8] = lane_rdata[i][7:0];
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    sram_lane_bank #(
      .DEPTH      (DEPTH),
      .LW         (LW),
      .RD_LATENCY (RD_LATENCY)
    ) u_bank (
      .clk   (HCLK),
      .we    (ram_we[g]),
      .addr  (ram_addr),
      .wdata (ram_wdata[g]),
      .rdata (lane_rdata[g])
    );
  end

  // Completion stage: ack, read data capture and parity flag.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
`ifdef SRAMCTRL_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      ack_q <= wr_done | rd_done;
      if (rd_done) rdata_q <= rd_word;
`ifdef SRAMCTRL_PARITY_EN
      perr_q <= rd_done & rd_par_bad;
`endif
    end
  end

  assign bus.sramahb_ack   = ack_q;
  assign bus.sramahb_rdata = rdata_q;
`ifdef SRAMCTRL_PARITY_EN
  assign bus.parity_err    = perr_q;
`else
  assign bus.parity_err    = 1'b0;
`endif

endmodule
